rpll_ctrl: RTL and testbench

Parametrised supervisor for a Gowin rPLL with dynamic divider selects enabled (DYN_IDIV/FBDIV/ODIV_SEL = "true"). It drives PLL reset and the IDSEL/FBDSEL/ODSEL buses, and filters the asynchronous LOCK. It releases per-domain resets in order, recovers from loss-of-lock with bounded retries, and accepts runtime divider reconfiguration over a req/ack handshake. Runs on the free-running PLL input clock; the rPLL primitive stays in its generated wrapper, wired to this block.

---
 rtl/rpll_ctrl_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/rpll_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_rpll_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rpll_ctrl_pkg.sv
// Shared types and widths for the rPLL supervisor.
//   state_t   : supervisor state encoding
//   pll_sel_t : IDSEL/FBDSEL/ODSEL payload as driven to the rPLL
package rpll_ctrl_pkg;

    localparam int unsigned SEL_W = 6;
    localparam int unsigned LOL_W = 8;

    typedef enum logic [2:0] {
        ST_PRST  = 3'd0,
        ST_WLOCK = 3'd1,
        ST_FILT  = 3'd2,
        ST_REL   = 3'd3,
        ST_RUN   = 3'd4,
        ST_FAIL  = 3'd5
    } state_t;

    typedef struct packed {
        logic [SEL_W-1:0] idsel;
        logic [SEL_W-1:0] fbdsel;
        logic [SEL_W-1:0] odsel;
    } pll_sel_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous status bits.
//   clk, rst_n : destination clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronised output (two cycles of latency)
module sync_2ff #(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rpll_ctrl.sv
// Supervisor for a Gowin rPLL with dynamic divider selects: pulses the PLL
// reset, filters LOCK, releases downstream domain resets in order, retries
// failed lock attempts and accepts divider reconfiguration over req/ack.
//   clk, rst_n            : PLL reference clock, async active-low reset
//   cfg_req, cfg_*sel     : reconfiguration request (level) and new selects
//   cfg_ack               : one-cycle accept pulse
//   pll_reset, pll_*sel   : to rPLL RESET and IDSEL/FBDSEL/ODSEL
//   pll_lock              : rPLL LOCK, asynchronous
//   dom_rst_n             : active-low domain resets, bit 0 released first
//   locked, fail          : status
//   retry_cnt, lol_cnt    : failed attempts in sequence, loss-of-lock events
module rpll_ctrl
    import rpll_ctrl_pkg::*;
#(
    parameter int unsigned      NUM_DOMAINS  = 2,
    parameter int unsigned      RST_HOLD     = 16,
    parameter int unsigned      LOCK_FILT    = 64,
    parameter int unsigned      LOCK_TIMEOUT = 65536,
    parameter int unsigned      MAX_RETRY    = 3,
    parameter int unsigned      DOM_GAP      = 8,
    parameter logic [SEL_W-1:0] DEF_IDSEL    = 6'd0,
    parameter logic [SEL_W-1:0] DEF_FBDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] DEF_ODSEL    = 6'd0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cfg_req,
    input  logic [SEL_W-1:0]                 cfg_idsel,
    input  logic [SEL_W-1:0]                 cfg_fbdsel,
    input  logic [SEL_W-1:0]                 cfg_odsel,
    output logic                             cfg_ack,
    output logic                             pll_reset,
    output logic [SEL_W-1:0]                 pll_idsel,
    output logic [SEL_W-1:0]                 pll_fbdsel,
    output logic [SEL_W-1:0]                 pll_odsel,
    input  logic                             pll_lock,
    output logic [NUM_DOMAINS-1:0]           dom_rst_n,
    output logic                             locked,
    output logic                             fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]   retry_cnt,
    output logic [LOL_W-1:0]                 lol_cnt
);

    localparam int unsigned RTY_W     = $clog2(MAX_RETRY + 1);
    localparam int unsigned REL_LAST  = (NUM_DOMAINS - 1) * DOM_GAP;
    localparam int unsigned CNT_MAX_A = (RST_HOLD > LOCK_FILT) ? RST_HOLD : LOCK_FILT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > REL_LAST) ? CNT_MAX_A : REL_LAST;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned TMO_W     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam pll_sel_t DEF_SEL = '{idsel: DEF_IDSEL, fbdsel: DEF_FBDSEL, odsel: DEF_ODSEL};

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [RTY_W-1:0]       retry_q, retry_d, retry_inc;
    logic [LOL_W-1:0]       lol_q, lol_d, lol_sat;
    pll_sel_t               sel_q, sel_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   locked_q, locked_d;
    logic                   fail_q, fail_d;
    logic                   ack_q, ack_d;
    logic                   pll_reset_q, pll_reset_d;
    logic                   armed_q, armed_d;

    logic                   lock_s;
    logic                   cfg_accept;
    logic                   rel_go;
    logic                   lol_drop;
    logic                   cfg_load;
    logic [CNT_W-1:0]       rel_k;

    // LOCK is asynchronous to the reference clock
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign retry_inc  = retry_q + RTY_W'(1);
    assign lol_sat    = (lol_q == '1) ? lol_q : lol_q + LOL_W'(1);
    // One accept per request level; armed again once cfg_req is seen low
    assign cfg_accept = cfg_req & armed_q & ((state_q == ST_RUN) | (state_q == ST_FAIL));

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        retry_d     = retry_q;
        lol_d       = lol_q;
        sel_d       = sel_q;
        dom_d       = dom_q;
        locked_d    = locked_q;
        fail_d      = fail_q;
        ack_d       = 1'b0;
        pll_reset_d = pll_reset_q;
        armed_d     = armed_q | ~cfg_req;
        rel_go      = 1'b0;
        lol_drop    = 1'b0;
        cfg_load    = 1'b0;
        rel_k       = '0;

        case (state_q)
            ST_PRST: begin
                if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                    state_d     = ST_WLOCK;
                    pll_reset_d = 1'b0;
                    tmo_d       = '0;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // Timer spans WLOCK and FILT; a lock drop in FILT does not restart it
            ST_WLOCK, ST_FILT: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_q == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    retry_d     = retry_inc;
                    pll_reset_d = 1'b1;
                    cnt_d       = '0;
                    if (retry_inc == RTY_W'(MAX_RETRY)) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_PRST;
                    end
                end else if (state_q == ST_WLOCK) begin
                    if (lock_s) begin
                        state_d = ST_FILT;
                        cnt_d   = '0;
                    end
                end else if (!lock_s) begin
                    state_d = ST_WLOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_FILT - 1)) begin
                    rel_go = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL: begin
                if (!lock_s) begin
                    lol_drop = 1'b1;
                end else begin
                    rel_go = 1'b1;
                    rel_k  = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_accept) begin
                    cfg_load = 1'b1;
                    if (!lock_s) begin
                        lol_d = lol_sat;
                    end
                end else if (!lock_s) begin
                    lol_drop = 1'b1;
                end
            end
            ST_FAIL: begin
                if (cfg_accept) begin
                    cfg_load = 1'b1;
                end
            end
            default: begin
                state_d     = ST_PRST;
                pll_reset_d = 1'b1;
                cnt_d       = '0;
            end
        endcase

        // Release step k: bit i is high once k >= i*DOM_GAP
        if (rel_go) begin
            dom_d[0] = 1'b1;
            for (int unsigned i = 1; i < NUM_DOMAINS; i++) begin
                dom_d[i] = (rel_k >= CNT_W'(i * DOM_GAP));
            end
            if (rel_k == CNT_W'(REL_LAST)) begin
                state_d  = ST_RUN;
                locked_d = 1'b1;
                retry_d  = '0;
                cnt_d    = '0;
            end else begin
                state_d = ST_REL;
                cnt_d   = rel_k;
            end
        end

        if (lol_drop) begin
            state_d     = ST_PRST;
            pll_reset_d = 1'b1;
            cnt_d       = '0;
            dom_d       = '0;
            locked_d    = 1'b0;
            lol_d       = lol_sat;
        end

        if (cfg_load) begin
            state_d     = ST_PRST;
            pll_reset_d = 1'b1;
            cnt_d       = '0;
            sel_d       = '{idsel: cfg_idsel, fbdsel: cfg_fbdsel, odsel: cfg_odsel};
            ack_d       = 1'b1;
            armed_d     = 1'b0;
            dom_d       = '0;
            locked_d    = 1'b0;
            fail_d      = 1'b0;
            retry_d     = '0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PRST;
            cnt_q       <= '0;
            tmo_q       <= '0;
            retry_q     <= '0;
            lol_q       <= '0;
            sel_q       <= DEF_SEL;
            dom_q       <= '0;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            ack_q       <= 1'b0;
            pll_reset_q <= 1'b1;
            armed_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            retry_q     <= retry_d;
            lol_q       <= lol_d;
            sel_q       <= sel_d;
            dom_q       <= dom_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            ack_q       <= ack_d;
            pll_reset_q <= pll_reset_d;
            armed_q     <= armed_d;
        end
    end

    assign cfg_ack    = ack_q;
    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = sel_q.idsel;
    assign pll_fbdsel = sel_q.fbdsel;
    assign pll_odsel  = sel_q.odsel;
    assign dom_rst_n  = dom_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign retry_cnt  = retry_q;
    assign lol_cnt    = lol_q;

endmodule

// File: tb/tb_rpll_ctrl.sv
// Self-checking bench for rpll_ctrl: hand-derived bring-up table, directed
// corner sequences and random lock/cfg traffic against a phase-level model.
module tb_rpll_ctrl;

    localparam int unsigned NUM_DOMAINS  = 3;
    localparam int unsigned RST_HOLD     = 4;
    localparam int unsigned LOCK_FILT    = 8;
    localparam int unsigned LOCK_TIMEOUT = 100;
    localparam int unsigned MAX_RETRY    = 2;
    localparam int unsigned DOM_GAP      = 2;
    localparam logic [5:0]  DEF_ID       = 6'd1;
    localparam logic [5:0]  DEF_FB       = 6'd2;
    localparam logic [5:0]  DEF_OD       = 6'd3;
    localparam int          REL_LAST     = (NUM_DOMAINS - 1) * DOM_GAP;

    localparam int P_PRST = 0, P_WAIT = 1, P_FILT = 2, P_REL = 3, P_RUN = 4, P_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_req;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       cfg_ack;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock;
    logic [2:0] dom_rst_n;
    logic       locked, fail;
    logic [1:0] retry_cnt;
    logic [7:0] lol_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    rpll_ctrl #(
        .NUM_DOMAINS  (NUM_DOMAINS),
        .RST_HOLD     (RST_HOLD),
        .LOCK_FILT    (LOCK_FILT),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .MAX_RETRY    (MAX_RETRY),
        .DOM_GAP      (DOM_GAP),
        .DEF_IDSEL    (DEF_ID),
        .DEF_FBDSEL   (DEF_FB),
        .DEF_ODSEL    (DEF_OD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_req    (cfg_req),
        .cfg_idsel  (cfg_idsel),
        .cfg_fbdsel (cfg_fbdsel),
        .cfg_odsel  (cfg_odsel),
        .cfg_ack    (cfg_ack),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .pll_lock   (pll_lock),
        .dom_rst_n  (dom_rst_n),
        .locked     (locked),
        .fail       (fail),
        .retry_cnt  (retry_cnt),
        .lol_cnt    (lol_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (phase + elapsed cycles) ----------------
    int         m_ph, m_e, m_tmo, m_run, m_retry, m_lol;
    logic       m_s1, m_s2, m_armed, m_ack;
    logic [5:0] m_id, m_fb, m_od;

    task automatic model_reset();
        m_ph = P_PRST; m_e = 0; m_tmo = 0; m_run = 0; m_retry = 0; m_lol = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; m_armed = 1'b1; m_ack = 1'b0;
        m_id = DEF_ID; m_fb = DEF_FB; m_od = DEF_OD;
    endtask

    task automatic model_lol_inc();
        if (m_lol < 255) m_lol++;
    endtask

    task automatic model_update(input logic lk, input logic rq,
                                input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        logic ls, acc;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = lk;
        acc  = rq && m_armed && (m_ph == P_RUN || m_ph == P_FAIL);
        m_armed = (m_armed || !rq) && !acc;
        m_ack = acc;
        case (m_ph)
            P_PRST: begin
                m_e++;
                if (m_e == RST_HOLD) begin m_ph = P_WAIT; m_tmo = 0; end
            end
            P_WAIT, P_FILT: begin
                m_tmo++;
                if (m_tmo == LOCK_TIMEOUT) begin
                    m_retry++;
                    m_ph = (m_retry == MAX_RETRY) ? P_FAIL : P_PRST;
                    m_e  = 0;
                end else if (m_ph == P_WAIT) begin
                    if (ls) begin m_ph = P_FILT; m_run = 0; end
                end else if (!ls) begin
                    m_ph = P_WAIT;
                end else begin
                    m_run++;
                    if (m_run == LOCK_FILT) begin
                        m_ph = P_REL; m_e = 0;
                        if (REL_LAST == 0) begin m_ph = P_RUN; m_retry = 0; end
                    end
                end
            end
            P_REL: begin
                if (!ls) begin model_lol_inc(); m_ph = P_PRST; m_e = 0; end
                else begin
                    m_e++;
                    if (m_e == REL_LAST) begin m_ph = P_RUN; m_retry = 0; end
                end
            end
            P_RUN: begin
                if (acc) begin
                    m_id = a; m_fb = b; m_od = c; m_retry = 0; m_ph = P_PRST; m_e = 0;
                    if (!ls) model_lol_inc();
                end else if (!ls) begin
                    model_lol_inc(); m_ph = P_PRST; m_e = 0;
                end
            end
            default: begin
                if (acc) begin
                    m_id = a; m_fb = b; m_od = c; m_retry = 0; m_ph = P_PRST; m_e = 0;
                end
            end
        endcase
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic logic [34:0] act_vec();
        return {pll_reset, pll_idsel, pll_fbdsel, pll_odsel, dom_rst_n, locked, fail,
                cfg_ack, retry_cnt, lol_cnt};
    endfunction

    function automatic logic [34:0] exp_vec();
        logic [2:0] d;
        d = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (m_ph == P_RUN) d[i] = 1'b1;
            else if (m_ph == P_REL && m_e >= i * DOM_GAP) d[i] = 1'b1;
        end
        return {(m_ph == P_PRST || m_ph == P_FAIL), m_id, m_fb, m_od, d,
                (m_ph == P_RUN), (m_ph == P_FAIL), m_ack, 2'(m_retry), 8'(m_lol)};
    endfunction

    int cyc = 0;

    // Advance one clock; inputs seen at the edge feed the model
    task automatic step();
        logic lk, rq, rn;
        logic [5:0] a, b, c;
        @(posedge clk);
        lk = pll_lock; rq = cfg_req; rn = rst_n;
        a = cfg_idsel; b = cfg_fbdsel; c = cfg_odsel;
        #1;
        cyc++;
        if (!rn) model_reset();
        else model_update(lk, rq, a, b, c);
        check("model", cyc, 64'(act_vec()), 64'(exp_vec()));
    endtask

    typedef struct {
        logic       lock;
        int         adv;
        logic [2:0] dom;
        logic       lck;
        logic       prst;
        logic [7:0] lol;
    } vec_t;

    vec_t tbl[12];

    int         hi_run, rises, first_retry, acks, seen, len;
    logic       prev_rst;

    initial begin
        // hand-derived bring-up: lock rises in cycle 10, drops in cycle 25
        tbl[0]  = '{1'b0, 0,  3'b000, 1'b0, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 3,  3'b000, 1'b0, 1'b1, 8'd0};
        tbl[2]  = '{1'b0, 1,  3'b000, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 6,  3'b000, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 10, 3'b000, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1,  3'b001, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1,  3'b001, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1,  3'b011, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1,  3'b011, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1,  3'b111, 1'b1, 1'b0, 8'd0};
        tbl[10] = '{1'b0, 2,  3'b111, 1'b1, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 1,  3'b000, 1'b0, 1'b1, 8'd1};

        rst_n = 1'b0; pll_lock = 1'b0; cfg_req = 1'b0;
        cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;

        // normal bring-up and loss of lock
        for (int r = 0; r < 12; r++) begin
            pll_lock = tbl[r].lock;
            for (int k = 0; k < tbl[r].adv; k++) step();
            check("tbl", r, 64'({dom_rst_n, locked, pll_reset, lol_cnt}),
                  64'({tbl[r].dom, tbl[r].lck, tbl[r].prst, tbl[r].lol}));
        end
        check("tbl_retry", 0, 64'(retry_cnt), 64'd0);

        // relock after loss
        pll_lock = 1'b1;
        for (int k = 0; k < 100 && !locked; k++) step();
        check("relock", 0, 64'({locked, dom_rst_n}), 64'({1'b1, 3'b111}));

        // glitchy lock: 5 high, 1 low, then steady
        pll_lock = 1'b0;
        for (int k = 0; k < 10 && !pll_reset; k++) step();
        for (int k = 0; k < 10 && pll_reset; k++) step();
        pll_lock = 1'b1;
        repeat (5) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        hi_run = 0;
        for (int k = 0; k < 60 && !dom_rst_n[0]; k++) begin
            step();
            hi_run++;
        end
        check("glitch_filter", 0, 64'(dom_rst_n[0] && hi_run >= LOCK_FILT), 64'd1);
        for (int k = 0; k < 20 && !locked; k++) step();
        check("glitch_locked", 0, 64'(locked), 64'd1);

        // reconfig: request held 5 cycles gives a single ack
        cfg_req = 1'b1; cfg_idsel = 6'd4; cfg_fbdsel = 6'd1; cfg_odsel = 6'd48;
        acks = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (cfg_ack) acks++;
        end
        cfg_req = 1'b0;
        check("cfg_one_ack", 0, 64'(acks), 64'd1);
        check("cfg_sel", 0, 64'({pll_idsel, pll_fbdsel, pll_odsel}), 64'({6'd4, 6'd1, 6'd48}));
        for (int k = 0; k < 100 && !locked; k++) step();
        check("cfg_relock", 0, 64'({locked, dom_rst_n}), 64'({1'b1, 3'b111}));

        // timeout: two failed attempts reach FAIL
        pll_lock = 1'b0;
        for (int k = 0; k < 10 && !pll_reset; k++) step();
        for (int k = 0; k < 10 && pll_reset; k++) step();
        rises = 0; first_retry = -1; prev_rst = pll_reset;
        for (int k = 0; k < 400 && !fail; k++) begin
            step();
            if (pll_reset && !prev_rst) begin
                rises++;
                if (rises == 1) first_retry = int'(retry_cnt);
            end
            prev_rst = pll_reset;
        end
        check("tmo_pulses", 0, 64'(rises), 64'd2);
        check("tmo_retry1", 0, 64'(first_retry), 64'd1);
        check("tmo_fail", 0, 64'({fail, retry_cnt, pll_reset}), 64'({1'b1, 2'd2, 1'b1}));
        repeat (20) step();
        check("fail_hold", 0, 64'({fail, pll_reset, dom_rst_n}), 64'({1'b1, 1'b1, 3'b000}));

        // recovery from FAIL by reconfiguration
        cfg_req = 1'b1; cfg_idsel = 6'd7; cfg_fbdsel = 6'd8; cfg_odsel = 6'd9;
        seen = 0;
        for (int k = 0; k < 5 && !seen; k++) begin
            step();
            if (cfg_ack) seen = 1;
        end
        check("fail_ack", 0, 64'({seen[0], fail, retry_cnt}), 64'({1'b1, 1'b0, 2'd0}));
        cfg_req = 1'b0;
        pll_lock = 1'b1;
        for (int k = 0; k < 100 && !locked; k++) step();
        check("fail_recover", 0, 64'(locked), 64'd1);

        // async reset in the middle of the release sequence
        pll_lock = 1'b0;
        for (int k = 0; k < 10 && !pll_reset; k++) step();
        pll_lock = 1'b1;
        for (int k = 0; k < 100 && dom_rst_n != 3'b011; k++) step();
        check("rel_mid", 0, 64'(dom_rst_n), 64'(3'b011));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", 0, 64'(act_vec()),
              64'({1'b1, DEF_ID, DEF_FB, DEF_OD, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0}));
        pll_lock = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // random lock and reconfiguration traffic
        for (int seg = 0; seg < 60; seg++) begin
            pll_lock = ($urandom_range(0, 3) != 0);
            len = int'($urandom_range(1, 120));
            for (int k = 0; k < len; k++) begin
                if (cfg_req) begin
                    if ($urandom_range(0, 3) == 0) cfg_req = 1'b0;
                end else if ($urandom_range(0, 40) == 0) begin
                    cfg_req    = 1'b1;
                    cfg_idsel  = 6'($urandom);
                    cfg_fbdsel = 6'($urandom);
                    cfg_odsel  = 6'($urandom);
                end
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
